mcdf_ctrl_regs_n: RTL and testbench
===================================

Name: mcdf_ctrl_regs_n

Overview:
Parametrised N-channel control/status register file for the MCDF arbiter and formatter. It generalises the fixed 3-slave register block to NUM_CH channels with configurable field widths. Additions over the fixed block: registered one-cycle read with a valid strobe, a software lock, and a saturating error counter for illegal accesses. It sits between the command bus and the per-slave enable/length/priority controls.

Parameters:
NUM_CH, 4, number of slave channels (1..16)
ADDR_W, 8, command address width
DATA_W, 32, command data width (>= 8)
LEN_W, 3, per-channel packet length field width
PRIO_W, 2, per-channel priority field width
AVAIL_W, 8, per-channel FIFO availability width
ERR_W, 8, error counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active high
cmd_i  in  2  2'b00 IDLE, 2'b10 WR, 2'b01 RD, 2'b11 illegal
cmd_addr_i  in  ADDR_W  byte address
cmd_data_i  in  DATA_W  write data
cmd_data_o  out  DATA_W  read data, registered
cmd_rvalid_o  out  1  one-cycle strobe; cmd_data_o is valid this cycle
slv_avail_i  in  NUM_CH*AVAIL_W  packed FIFO availability, ch0 in LSBs
slv_len_o  out  NUM_CH*LEN_W  packed length fields
slv_prio_o  out  NUM_CH*PRIO_W  packed priority fields
slv_en_o  out  NUM_CH  per-channel enable
lock_o  out  1  current lock state

Behaviour:
- The clock is clk_i. Reset is asynchronous and active-high (rst_i). All state is flopped and cleared by rst_i asynchronously.
- Reset values:
  - en = 1, len = 0, prio = all ones, for every channel.
  - lock = 0, err_cnt = 0.
  - cmd_data_o = 0, cmd_rvalid_o = 0.
- Address map. An address is legal only if it is word-aligned (addr[1:0]==0) and hits one of these entries:
  - CTRL[ch] at 0x00+4*ch, ch < NUM_CH, RW. Bit layout: bit0 = en; bits[LEN_W:1] = len; bits[LEN_W+PRIO_W:LEN_W+1] = prio; other bits read 0 and writes to them are dropped.
  - STAT[ch] at 0x40+4*ch, ch < NUM_CH, RO. Bits[AVAIL_W-1:0] = slv_avail_i of that channel, sampled in the RD cycle; upper bits 0.
  - ERRCNT at 0x80, RO, read-to-clear. Bits[ERR_W-1:0] = err_cnt.
  - GLOBAL at 0x84, RW. Bit0 = lock.
- Write (cmd_i = WR, legal RW address): the register updates at the clock edge ending the command cycle. Outputs reflect the new value the next cycle (1-cycle latency).
- Lock:
  - Writing 1 to GLOBAL bit0 sets lock. Writing 0 does not clear it; only rst_i clears lock.
  - While lock = 1, CTRL writes are dropped and counted as errors.
  - GLOBAL writes while locked are accepted (no effect, no error).
- Read (cmd_i = RD):
  - cmd_data_o and cmd_rvalid_o are registered. They are asserted in the cycle after the RD and hold the data for exactly one cycle.
  - In every other cycle cmd_rvalid_o = 0 and cmd_data_o = 0.
  - Back-to-back RDs produce back-to-back rvalid pulses.
- Read-then-write on the same address in consecutive cycles: the read returns the pre-write value.
- Error events: each one increments err_cnt by one, saturating at all ones (no wrap). An error event is any of:
  - cmd_i = 2'b11;
  - RD or WR to an unaligned or unmapped address;
  - WR to STAT or ERRCNT;
  - CTRL WR while locked.
- RD to an illegal address returns 0 with cmd_rvalid_o = 1 and counts as an error.
- RD of ERRCNT returns the value before the clear. The counter becomes 0 at the same edge.
- Channels >= NUM_CH are unmapped, even if the address lies inside the 0x00-0x3C or 0x40-0x7C window.
- Reset asserted mid-operation: an in-flight read strobe is killed (rvalid = 0 immediately, asynchronously). A WR in the same cycle as reset is lost.

Test Plan:
- Reset, then RD 0x00..0x0C with NUM_CH=4, LEN_W=3, PRIO_W=2 -> each returns 0x31 one cycle later with rvalid=1. slv_en_o=4'hF, slv_prio_o=8'hFF, slv_len_o=0.
- WR 0x08 data 0x0000_001B, then RD 0x08 -> read data 0x1B. ch2 en=1, len=5, prio=1 from the cycle after the WR. RD issued in the WR cycle+1 returns 0x1B; RD in the WR cycle itself would return 0x31.
- Drive slv_avail_i ch1=0xA5, RD 0x44 -> 0x0000_00A5. Then WR 0x44 -> no state change and ERRCNT reads 1. A second RD of 0x80 returns 0.
- WR 0x84 data 1, then WR 0x00 data 0 -> ch0 en stays 1, lock_o=1. WR 0x84 data 0 -> lock_o remains 1. ERRCNT reads 1.
- Issue 300 commands with cmd_i=2'b11 -> ERRCNT reads 0xFF (saturated). An immediate re-read returns 0.
- Set ch0 en=0, issue RD, and assert rst_i in the rvalid cycle -> rvalid drops immediately. After reset, ch0 en=1 and lock=0.

Source files
------------

// File: rtl/mcdf_ctrl_regs_n.sv
// mcdf_ctrl_regs_n: N-channel control/status register file for the MCDF
// arbiter/formatter. Per-channel CTRL (en/len/prio), read-only STAT
// (FIFO availability), read-to-clear saturating ERRCNT and a sticky
// software lock in GLOBAL. Reads are registered with a one-cycle strobe.
module mcdf_ctrl_regs_n #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 3,
  parameter int PRIO_W  = 2,
  parameter int AVAIL_W = 8,
  parameter int ERR_W   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  cmd_i,
  input  logic [ADDR_W-1:0]           cmd_addr_i,
  input  logic [DATA_W-1:0]           cmd_data_i,
  output logic [DATA_W-1:0]           cmd_data_o,
  output logic                        cmd_rvalid_o,
  input  logic [NUM_CH*AVAIL_W-1:0]   slv_avail_i,
  output logic [NUM_CH*LEN_W-1:0]     slv_len_o,
  output logic [NUM_CH*PRIO_W-1:0]    slv_prio_o,
  output logic [NUM_CH-1:0]           slv_en_o,
  output logic                        lock_o
);

  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_BAD = 2'b11;

  logic [NUM_CH-1:0]             en_q;
  logic [NUM_CH-1:0][LEN_W-1:0]  len_q;
  logic [NUM_CH-1:0][PRIO_W-1:0] prio_q;
  logic                          lock_q;
  logic [ERR_W-1:0]              err_q;

  logic [31:0]       waddr;
  logic [3:0]        ch;
  logic              aligned, ctrl_hit, stat_hit, err_hit, glb_hit, legal;
  logic              is_rd, is_wr, ctrl_wr, err_ev, err_clr;
  logic [DATA_W-1:0] rd_mux;

  // Word index of the command address; channel index is its low nibble
  // for both the CTRL (0x00) and STAT (0x40) windows.
  assign waddr    = 32'(cmd_addr_i[ADDR_W-1:2]);
  assign ch       = waddr[3:0];
  assign aligned  = (cmd_addr_i[1:0] == 2'b00);
  assign ctrl_hit = aligned && (waddr < 32'(NUM_CH));
  assign stat_hit = aligned && (waddr >= 32'd16) && (waddr < 32'(16 + NUM_CH));
  assign err_hit  = aligned && (waddr == 32'd32);
  assign glb_hit  = aligned && (waddr == 32'd33);
  assign legal    = ctrl_hit || stat_hit || err_hit || glb_hit;

  assign is_rd    = (cmd_i == CMD_RD);
  assign is_wr    = (cmd_i == CMD_WR);
  assign ctrl_wr  = is_wr && ctrl_hit && !lock_q;
  assign err_clr  = is_rd && err_hit;
  assign err_ev   = (cmd_i == CMD_BAD)
                 || ((is_rd || is_wr) && !legal)
                 || (is_wr && (stat_hit || err_hit))
                 || (is_wr && ctrl_hit && lock_q);

  // Only the CTRL field bits of the write data are stored.
  logic unused_data;
  assign unused_data = ^cmd_data_i[DATA_W-1:LEN_W+PRIO_W+1];

  // Read data mux; anything not decoded returns zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ctrl_hit && ch == 4'(i))
        rd_mux = DATA_W'({prio_q[i], len_q[i], en_q[i]});
      if (stat_hit && ch == 4'(i))
        rd_mux = DATA_W'(slv_avail_i[i*AVAIL_W +: AVAIL_W]);
    end
    if (err_hit) rd_mux = DATA_W'(err_q);
    if (glb_hit) rd_mux = DATA_W'(lock_q);
  end

  // Per-channel CTRL registers; writes are blocked while locked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q   <= '1;
      len_q  <= '0;
      prio_q <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ctrl_wr && ch == 4'(i)) begin
          en_q[i]   <= cmd_data_i[0];
          len_q[i]  <= cmd_data_i[LEN_W:1];
          prio_q[i] <= cmd_data_i[LEN_W+PRIO_W:LEN_W+1];
        end
      end
    end
  end

  // Sticky lock: only a 1 write changes it, only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                 lock_q <= 1'b0;
    else if (is_wr && glb_hit && cmd_data_i[0]) lock_q <= 1'b1;
  end

  // Error counter: read-to-clear wins, otherwise saturating increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      err_q <= '0;
    else if (err_clr)               err_q <= '0;
    else if (err_ev && err_q != '1) err_q <= err_q + ERR_W'(1);
  end

  // Registered read port: data is zero whenever the strobe is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_rvalid_o <= 1'b0;
      cmd_data_o   <= '0;
    end else begin
      cmd_rvalid_o <= is_rd;
      cmd_data_o   <= is_rd ? rd_mux : '0;
    end
  end

  assign slv_en_o   = en_q;
  assign slv_len_o  = len_q;
  assign slv_prio_o = prio_q;
  assign lock_o     = lock_q;

endmodule

// File: tb/tb_mcdf_ctrl_regs_n.sv
// Bench for mcdf_ctrl_regs_n: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural register-map model.
module tb_mcdf_ctrl_regs_n;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  cmd_i = 2'b00;
  logic [7:0]  cmd_addr_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic [31:0] cmd_data_o;
  logic        cmd_rvalid_o;
  logic [31:0] slv_avail_i = '0;
  logic [11:0] slv_len_o;
  logic [7:0]  slv_prio_o;
  logic [3:0]  slv_en_o;
  logic        lock_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic       en_m [NCH];
  logic [2:0] len_m [NCH];
  logic [1:0] prio_m [NCH];
  logic       lock_m;
  int         err_m;

  mcdf_ctrl_regs_n #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .LEN_W(3),
                     .PRIO_W(2), .AVAIL_W(8), .ERR_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_i(cmd_i), .cmd_addr_i(cmd_addr_i),
    .cmd_data_i(cmd_data_i), .cmd_data_o(cmd_data_o),
    .cmd_rvalid_o(cmd_rvalid_o), .slv_avail_i(slv_avail_i),
    .slv_len_o(slv_len_o), .slv_prio_o(slv_prio_o), .slv_en_o(slv_en_o),
    .lock_o(lock_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      en_m[i] = 1'b1; len_m[i] = 3'd0; prio_m[i] = 2'd3;
    end
    lock_m = 1'b0;
    err_m  = 0;
  endtask

  task automatic bump_err();
    if (err_m < 255) err_m = err_m + 1;
  endtask

  // Applies one command to the model; returns the expected read response.
  task automatic model_cmd(input logic [1:0] c, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] av,
                           output logic ev, output logic [31:0] ed);
    int  w;
    bit  al, is_ctrl, is_stat, is_err, is_glb, legal;
    w       = int'(a) / 4;
    al      = (int'(a) % 4 == 0);
    is_ctrl = al && w < NCH;
    is_stat = al && w >= 16 && w < 16 + NCH;
    is_err  = al && a == 8'h80;
    is_glb  = al && a == 8'h84;
    legal   = is_ctrl || is_stat || is_err || is_glb;
    ev = 1'b0; ed = 32'd0;
    if (c == 2'b11) bump_err();
    else if (c == 2'b01) begin
      ev = 1'b1;
      if (!legal) bump_err();
      else if (is_ctrl) ed = 32'(en_m[w]) + 32'(len_m[w]) * 2 + 32'(prio_m[w]) * 16;
      else if (is_stat) ed = (av >> (8 * (w - 16))) & 32'hFF;
      else if (is_err) begin ed = 32'(err_m); err_m = 0; end
      else ed = 32'(lock_m);
    end else if (c == 2'b10) begin
      if (!legal || is_stat || is_err) bump_err();
      else if (is_glb) begin if (d[0]) lock_m = 1'b1; end
      else if (lock_m) bump_err();
      else begin
        en_m[w]   = d[0];
        len_m[w]  = 3'((d >> 1) & 32'h7);
        prio_m[w] = 2'((d >> 4) & 32'h3);
      end
    end
  endtask

  task automatic check_outputs(input logic ev, input logic [31:0] ed);
    logic [3:0]  x_en;
    logic [11:0] x_len;
    logic [7:0]  x_prio;
    for (int i = 0; i < NCH; i++) begin
      x_en[i] = en_m[i]; x_len[i*3 +: 3] = len_m[i]; x_prio[i*2 +: 2] = prio_m[i];
    end
    checks += 6;
    if (cmd_rvalid_o !== ev) begin errors++; $display("FAIL rvalid: got %b expected %b", cmd_rvalid_o, ev); end
    if (cmd_data_o !== ed)   begin errors++; $display("FAIL rdata: got %h expected %h", cmd_data_o, ed); end
    if (slv_en_o !== x_en)   begin errors++; $display("FAIL slv_en: got %h expected %h", slv_en_o, x_en); end
    if (slv_len_o !== x_len) begin errors++; $display("FAIL slv_len: got %h expected %h", slv_len_o, x_len); end
    if (slv_prio_o !== x_prio) begin errors++; $display("FAIL slv_prio: got %h expected %h", slv_prio_o, x_prio); end
    if (lock_o !== lock_m)   begin errors++; $display("FAIL lock: got %b expected %b", lock_o, lock_m); end
  endtask

  // Drive one command for one cycle, then check the cycle after.
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
    logic        ev;
    logic [31:0] ed;
    cmd_i = c; cmd_addr_i = a; cmd_data_i = d;
    model_cmd(c, a, d, slv_avail_i, ev, ed);
    @(posedge clk); #1;
    check_outputs(ev, ed);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; cmd_i = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    check_outputs(1'b0, 32'd0);
    checks++;
    if (slv_en_o !== 4'hF || slv_prio_o !== 8'hFF || slv_len_o !== 12'h0) begin
      errors++;
      $display("FAIL reset_vals: got en=%h prio=%h len=%h expected en=f prio=ff len=0",
               slv_en_o, slv_prio_o, slv_len_o);
    end
  endtask

  task automatic test_ctrl_defaults();
    for (int i = 0; i < NCH; i++) do_cmd(2'b01, 8'(4 * i), 32'd0);
    do_cmd(2'b00, 8'h00, 32'd0);
  endtask

  task automatic test_write_read();
    do_cmd(2'b10, 8'h08, 32'h0000_001B);
    do_cmd(2'b01, 8'h08, 32'd0);
    // read-then-write same address: read returns the old value
    do_cmd(2'b01, 8'h0C, 32'd0);
    do_cmd(2'b10, 8'h0C, 32'h0000_0026);
    do_cmd(2'b01, 8'h0C, 32'd0);
    // unaligned and unmapped-channel accesses
    do_cmd(2'b01, 8'h09, 32'd0);
    do_cmd(2'b10, 8'h10, 32'h7F);
    do_cmd(2'b01, 8'h50, 32'd0);
    do_cmd(2'b01, 8'h80, 32'd0);
    do_cmd(2'b00, 8'h00, 32'd0);
  endtask

  task automatic test_stat();
    slv_avail_i = 32'h12_34_A5_5A;
    do_cmd(2'b01, 8'h44, 32'd0);
    do_cmd(2'b10, 8'h44, 32'hFFFF_FFFF);
    do_cmd(2'b01, 8'h80, 32'd0);
    do_cmd(2'b01, 8'h80, 32'd0);
    do_cmd(2'b01, 8'h4C, 32'd0);
    do_cmd(2'b00, 8'h00, 32'd0);
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a = 8'(4 * $urandom_range(0, 5));
        1: a = 8'(8'h40 + 4 * $urandom_range(0, 5));
        2: a = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h84;
        default: a = 8'($urandom_range(0, 255));
      endcase
      d = $urandom;
      if (a == 8'h84) d[0] = ($urandom_range(0, 15) == 0);
      slv_avail_i = $urandom;
      do_cmd(2'($urandom_range(0, 3)), a, d);
    end
    do_cmd(2'b00, 8'h00, 32'd0);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 300; n++) do_cmd(2'b11, 8'($urandom_range(0, 255)), $urandom);
    do_cmd(2'b01, 8'h80, 32'd0);
    do_cmd(2'b01, 8'h80, 32'd0);
    do_cmd(2'b00, 8'h00, 32'd0);
  endtask

  task automatic test_lock();
    apply_reset();
    do_cmd(2'b10, 8'h84, 32'd1);
    do_cmd(2'b10, 8'h00, 32'd0);
    do_cmd(2'b10, 8'h84, 32'd0);
    do_cmd(2'b01, 8'h84, 32'd0);
    do_cmd(2'b01, 8'h80, 32'd0);
    do_cmd(2'b01, 8'h00, 32'd0);
    do_cmd(2'b00, 8'h00, 32'd0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_cmd(2'b10, 8'h00, 32'd0);
    do_cmd(2'b01, 8'h00, 32'd0);   // strobe is high now
    cmd_i = 2'b00;
    rst_i = 1'b1;
    #1;
    checks += 3;
    if (cmd_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_kill_rvalid: got %b expected 0", cmd_rvalid_o); end
    if (cmd_data_o !== 32'd0)  begin errors++; $display("FAIL rst_kill_rdata: got %h expected 0", cmd_data_o); end
    if (slv_en_o !== 4'hF || lock_o !== 1'b0) begin
      errors++; $display("FAIL rst_restore: got en=%h lock=%b expected en=f lock=0", slv_en_o, lock_o);
    end
    @(posedge clk); #1 rst_i = 1'b0;
    model_reset();
    do_cmd(2'b01, 8'h00, 32'd0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ctrl_defaults();
    test_write_read();
    test_stat();
    test_random();
    test_saturate();
    test_lock();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
